fg_sram_arbiter: RTL and testbench

//  Shares the single-port foreground SRAM between the pipeline's fixed-latency pixel reads and foreground capture writes.

---
 rtl/fg_sram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_fg_sram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_sram_arbiter.sv
// fg_sram_arbiter: shares the single-port foreground SRAM between fixed-latency
// pipeline pixel reads (always win) and FIFO-buffered foreground capture writes.
// Writes drain only in cycles where no in-range read is being issued.
module fg_sram_arbiter #(
    parameter int PRECISION                    = 11,
    parameter int PIXEL_SIZE                   = 16,
    parameter int ADDR_WIDTH                   = 19,
    parameter int RESOLUTION_X                 = 800,
    parameter int RESOLUTION_Y                 = 600,
    parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5,
    parameter int SRAM_READ_LATENCY            = 2,
    parameter int WFIFO_DEPTH                  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_active,
    input  logic [PRECISION:0]    rd_req_x,
    input  logic [PRECISION:0]    rd_req_y,
    output logic [PIXEL_SIZE-1:0] rd_pixel_out,
    output logic                  rd_pixel_skip,
    output logic                  rd_pixel_ready,
    input  logic                  wr_valid,
    input  logic [PRECISION-1:0]  wr_x,
    input  logic [PRECISION-1:0]  wr_y,
    input  logic [PIXEL_SIZE-1:0] wr_pixel,
    output logic                  wr_ready,
    input  logic                  fg_freeze,
    output logic [15:0]           wr_drop_count,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [PIXEL_SIZE-1:0] sram_wdata,
    input  logic [PIXEL_SIZE-1:0] sram_rdata
);

    localparam int D     = FOREGROUND_FETCH_CYCLE_DELAY;
    localparam int L     = SRAM_READ_LATENCY;
    localparam int FAW   = $clog2(WFIFO_DEPTH);
    localparam int MUL_W = 2 * PRECISION + 2;

    localparam logic [PRECISION:0]   RX_S     = (PRECISION+1)'(RESOLUTION_X);
    localparam logic [PRECISION:0]   RY_S     = (PRECISION+1)'(RESOLUTION_Y);
    localparam logic [PRECISION-1:0] RX_U     = PRECISION'(RESOLUTION_X);
    localparam logic [PRECISION-1:0] RY_U     = PRECISION'(RESOLUTION_Y);
    localparam logic [FAW:0]         FULL_CNT = (FAW+1)'(WFIFO_DEPTH);

    // Read side state: stage k holds the request sampled k+1 edges ago.
    logic [D-2:0]            valid_pipe_q;
    logic [D-2:0]            skip_pipe_q;
    logic                    ready_q;
    logic                    skip_q;
    logic [PIXEL_SIZE-1:0]   pixel_q;
    logic [PIXEL_SIZE-1:0]   resp_data;
    logic                    tag;

    // Write FIFO state
    logic [ADDR_WIDTH-1:0]   wf_addr_mem [0:WFIFO_DEPTH-1];
    logic [PIXEL_SIZE-1:0]   wf_data_mem [0:WFIFO_DEPTH-1];
    logic [FAW-1:0]          wr_ptr_q;
    logic [FAW-1:0]          rd_ptr_q;
    logic [FAW:0]            count_q;
    logic [FAW:0]            count_d;
    logic                    wr_ready_q;
    logic [15:0]             drop_cnt_q;

    // SRAM pin registers
    logic                    sram_en_q;
    logic                    sram_we_q;
    logic [ADDR_WIDTH-1:0]   sram_addr_q;
    logic [PIXEL_SIZE-1:0]   sram_wdata_q;

    logic                    rd_in_range;
    logic                    rd_issue;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    wr_take;
    logic                    push;
    logic                    drop;
    logic                    pop;

    // Request decode: sign bit set means negative, hence out of frame.
    assign rd_in_range = !rd_req_x[PRECISION] && !rd_req_y[PRECISION] &&
                         (rd_req_x < RX_S) && (rd_req_y < RY_S);
    assign rd_issue    = rd_req_active && rd_in_range;
    assign rd_addr     = ADDR_WIDTH'(MUL_W'(rd_req_y[PRECISION-1:0]) * MUL_W'(RESOLUTION_X)
                                     + MUL_W'(rd_req_x[PRECISION-1:0]));
    assign wr_addr     = ADDR_WIDTH'(MUL_W'(wr_y) * MUL_W'(RESOLUTION_X) + MUL_W'(wr_x));

    // Capture decode: frozen or out-of-frame captures vanish silently.
    assign wr_take = wr_valid && !fg_freeze && (wr_x < RX_U) && (wr_y < RY_U);
    assign push    = wr_take && wr_ready_q;
    assign drop    = wr_take && !wr_ready_q;
    assign pop     = (count_q != '0) && !rd_issue;

    // Next FIFO occupancy; push+pop together leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            wf_addr_mem[wr_ptr_q] <= wr_addr;
            wf_data_mem[wr_ptr_q] <= wr_pixel;
        end
    end

    // FIFO pointers, occupancy, ready flag and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            wr_ready_q <= (count_d != FULL_CNT);
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // SRAM port: an in-range read always takes the slot, otherwise drain one write.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else if (rd_issue) begin
            sram_en_q   <= 1'b1;
            sram_we_q   <= 1'b0;
            sram_addr_q <= rd_addr;
        end else if (pop) begin
            sram_en_q    <= 1'b1;
            sram_we_q    <= 1'b1;
            sram_addr_q  <= wf_addr_mem[rd_ptr_q];
            sram_wdata_q <= wf_data_mem[rd_ptr_q];
        end else begin
            sram_en_q <= 1'b0;
            sram_we_q <= 1'b0;
        end
    end

    // sram_rdata belongs to the request sitting in stage L this cycle.
    assign tag = valid_pipe_q[L] && !skip_pipe_q[L];

    generate
        if (D == L + 2) begin : g_direct
            assign resp_data = sram_rdata;
        end else begin : g_delay
            logic [PIXEL_SIZE-1:0] dly_q [0:D-L-3];
            // Carry captured read data down to the response stage.
            always_ff @(posedge clk) begin
                if (tag) dly_q[0] <= sram_rdata;
                for (int k = 1; k <= D - L - 3; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
            assign resp_data = dly_q[D-L-3];
        end
    endgenerate

    // In-flight read tracking and response generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe_q <= '0;
            skip_pipe_q  <= '0;
            ready_q      <= 1'b0;
            skip_q       <= 1'b0;
            pixel_q      <= '0;
        end else begin
            valid_pipe_q <= {valid_pipe_q[D-3:0], rd_req_active};
            skip_pipe_q  <= {skip_pipe_q[D-3:0], !rd_in_range};
            ready_q      <= valid_pipe_q[D-2];
            skip_q       <= valid_pipe_q[D-2] && skip_pipe_q[D-2];
            if (valid_pipe_q[D-2] && !skip_pipe_q[D-2]) begin
                pixel_q <= resp_data;
            end
        end
    end

    assign rd_pixel_out   = pixel_q;
    assign rd_pixel_skip  = skip_q;
    assign rd_pixel_ready = ready_q;
    assign wr_ready       = wr_ready_q;
    assign wr_drop_count  = drop_cnt_q;
    assign sram_en        = sram_en_q;
    assign sram_we        = sram_we_q;
    assign sram_addr      = sram_addr_q;
    assign sram_wdata     = sram_wdata_q;

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Scoreboard bench for fg_sram_arbiter: stimulus pushes expected responses,
// SRAM reads and SRAM writes into queues; a monitor pops and compares them.
module tb_fg_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_active;
    logic [11:0] rd_req_x, rd_req_y;
    logic [15:0] rd_pixel_out;
    logic        rd_pixel_skip, rd_pixel_ready;
    logic        wr_valid;
    logic [10:0] wr_x, wr_y;
    logic [15:0] wr_pixel;
    logic        wr_ready;
    logic        fg_freeze;
    logic [15:0] wr_drop_count;
    logic        sram_en, sram_we;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = 16'hDEAD;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; logic skip; logic [15:0] pix; } rsp_t;
    typedef struct { int cyc; logic [18:0] addr; }           rda_t;
    typedef struct { logic [18:0] addr; logic [15:0] data; } wre_t;

    rsp_t rsp_q[$];
    rda_t rda_q[$];
    wre_t wre_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fg_sram_arbiter #(
        .PRECISION(11), .PIXEL_SIZE(16), .ADDR_WIDTH(19),
        .RESOLUTION_X(800), .RESOLUTION_Y(600),
        .FOREGROUND_FETCH_CYCLE_DELAY(5), .SRAM_READ_LATENCY(2), .WFIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_active(rd_req_active), .rd_req_x(rd_req_x), .rd_req_y(rd_req_y),
        .rd_pixel_out(rd_pixel_out), .rd_pixel_skip(rd_pixel_skip), .rd_pixel_ready(rd_pixel_ready),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .wr_ready(wr_ready), .fg_freeze(fg_freeze), .wr_drop_count(wr_drop_count),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Foreground SRAM contents as seen by reads.
    function automatic logic [15:0] sram_fn(input logic [18:0] a);
        if (a == 19'd1610) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // SRAM model with a two-cycle read latency.
    logic [15:0] rd_stage1 = 16'hDEAD;
    always @(posedge clk) begin
        rd_stage1  <= (sram_en && !sram_we) ? sram_fn(sram_addr) : 16'hDEAD;
        sram_rdata <= rd_stage1;
    end

    // Monitor: compare every DUT response / SRAM access against the queues.
    always @(posedge clk) begin
        #1;
        if (rd_pixel_ready) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d skip=%b pix=%h required=no response", cyc, rd_pixel_skip, rd_pixel_out);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                if (e.cyc != cyc || e.skip != rd_pixel_skip || (!e.skip && e.pix != rd_pixel_out)) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d skip=%b pix=%h required cyc=%0d skip=%b pix=%h",
                             cyc, rd_pixel_skip, rd_pixel_out, e.cyc, e.skip, e.pix);
                end else begin
                    $display("rsp ok cyc=%0d skip=%b pix=%h", cyc, rd_pixel_skip, rd_pixel_out);
                end
            end
        end
        if (sram_en && !sram_we) begin
            checks++;
            if (rda_q.size() == 0) begin
                errors++;
                $display("FAIL sram_rd_unexpected cyc=%0d addr=%0d required=no read", cyc, sram_addr);
            end else begin
                rda_t r;
                r = rda_q.pop_front();
                if (r.cyc != cyc || r.addr != sram_addr) begin
                    errors++;
                    $display("FAIL sram_rd cyc=%0d addr=%0d required cyc=%0d addr=%0d", cyc, sram_addr, r.cyc, r.addr);
                end else begin
                    $display("sram rd ok cyc=%0d addr=%0d", cyc, sram_addr);
                end
            end
        end
        if (sram_en && sram_we) begin
            checks++;
            if (wre_q.size() == 0) begin
                errors++;
                $display("FAIL sram_wr_unexpected cyc=%0d addr=%0d data=%h required=no write", cyc, sram_addr, sram_wdata);
            end else begin
                wre_t w;
                w = wre_q.pop_front();
                if (w.addr != sram_addr || w.data != sram_wdata) begin
                    errors++;
                    $display("FAIL sram_wr cyc=%0d addr=%0d data=%h required addr=%0d data=%h",
                             cyc, sram_addr, sram_wdata, w.addr, w.data);
                end else begin
                    $display("sram wr ok cyc=%0d addr=%0d data=%h", cyc, sram_addr, sram_wdata);
                end
            end
        end
        if (!sram_en && sram_we) begin
            checks++;
            errors++;
            $display("FAIL sram_we_idle cyc=%0d sram_we=1 required=0", cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end else begin
            $display("%s ok cyc=%0d value=%0d", nm, cyc, act);
        end
    endtask

    // Advance one cycle; inputs return to idle and the caller sets this cycle's stimulus.
    task automatic tick();
        @(posedge clk);
        #2;
        rd_req_active = 1'b0;
        wr_valid      = 1'b0;
    endtask

    task automatic do_rd(input int x, input int y, input bit in_rng, input int a);
        rd_req_active = 1'b1;
        rd_req_x      = 12'(x);
        rd_req_y      = 12'(y);
        if (in_rng) rda_q.push_back('{cyc + 1, 19'(a)});
        rsp_q.push_back('{cyc + 5, !in_rng, in_rng ? sram_fn(19'(a)) : 16'h0000});
    endtask

    task automatic do_wr(input int x, input int y, input int d, input bit exp_push, input int a);
        wr_valid = 1'b1;
        wr_x     = 11'(x);
        wr_y     = 11'(y);
        wr_pixel = 16'(d);
        if (exp_push) wre_q.push_back('{19'(a), 16'(d)});
    endtask

    initial begin
        rst = 1'b1; rd_req_active = 1'b0; rd_req_x = '0; rd_req_y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0; fg_freeze = 1'b0;
        repeat (3) tick();
        chk("reset_sram_en", int'(sram_en), 0);
        chk("reset_ready", int'(rd_pixel_ready), 0);
        chk("reset_wr_ready", int'(wr_ready), 0);
        chk("reset_drop", int'(wr_drop_count), 0);
        rst = 1'b0;
        tick();
        chk("wr_ready_after_reset", int'(wr_ready), 1);

        // Single in-range read at (10,2) -> address 1610, data BEEF.
        do_rd(10, 2, 1, 1610);
        tick();
        repeat (6) tick();

        // Out-of-frame reads back to back, then the far corner (799,599).
        do_rd(-1, 0, 0, 0);    tick();
        do_rd(800, 0, 0, 0);   tick();
        do_rd(0, 600, 0, 0);   tick();
        do_rd(799, 599, 1, 479999); tick();
        repeat (6) tick();

        // Fill the FIFO during continuous reads; the ninth capture is dropped.
        for (int i = 0; i < 14; i++) begin
            if (i == 8) chk("wr_ready_full", int'(wr_ready), 0);
            if (i == 9) chk("drop_after_9th", int'(wr_drop_count), 1);
            do_rd(100 + i, 1, 1, 900 + i);
            if (i < 9) do_wr(i, 5, 16'h1000 + i, i < 8, 4000 + i);
            tick();
        end
        repeat (14) tick();
        chk("wr_ready_drained", int'(wr_ready), 1);

        // Reset mid-stream: in-flight reads must never respond.
        do_rd(5, 0, 1, 5); tick();
        do_rd(6, 0, 1, 6); tick();
        rsp_q.delete();
        rst = 1'b1;
        tick();
        chk("rst_sram_en", int'(sram_en), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_wr_ready", int'(wr_ready), 1);
        chk("post_rst_drop", int'(wr_drop_count), 0);
        chk("post_rst_sram_en", int'(sram_en), 0);
        repeat (6) tick();

        // Alternating read/write; out-of-frame captures are discarded, not dropped.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) do_rd(i, 3, 1, 2400 + i);
            else            do_wr(i, 7, 16'h2000 + i, 1, 5600 + i);
            tick();
        end
        do_wr(800, 7, 16'h3333, 0, 0); tick();
        do_wr(3, 600, 16'h4444, 0, 0); tick();
        repeat (8) tick();
        chk("drop_oof", int'(wr_drop_count), 0);

        // Pre-load 3 writes under reads, then freeze with captures still arriving.
        for (int i = 0; i < 5; i++) begin
            do_rd(200 + i, 0, 1, 200 + i);
            if (i < 3) do_wr(20 + i, 9, 16'h5000 + i, 1, 7220 + i);
            tick();
        end
        fg_freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_wr(40 + i, 9, 16'h6000 + i, 0, 0);
            tick();
        end
        chk("freeze_drop", int'(wr_drop_count), 0);
        chk("freeze_wr_ready", int'(wr_ready), 1);
        fg_freeze = 1'b0;
        repeat (10) tick();

        chk("rsp_left", rsp_q.size(), 0);
        chk("rd_left", rda_q.size(), 0);
        chk("wr_left", wre_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
